// File: rtl/elastic_pe_v2.sv
// elastic_pe_v2: context-driven elastic CGRA PE with multi-cycle ALU, output FIFO and masked fork
module elastic_pe_v2 #(
  parameter int NUM_NEIGHBOR = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CTX_DEPTH = 16,
  parameter int BUF_DEPTH = 2,
  parameter int LAT_ADD = 1,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 8,
  parameter int LAT_LOAD = 2,
  localparam int NB_W = (NUM_NEIGHBOR > 1) ? $clog2(NUM_NEIGHBOR) : 1,
  localparam int CTX_W = $clog2(CTX_DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cfg_we,
  input  logic [CTX_W-1:0]               cfg_idx,
  input  logic [NB_W-1:0]                cfg_src_a,
  input  logic [NB_W-1:0]                cfg_src_b,
  input  logic [NUM_NEIGHBOR-1:0]        cfg_out_mask,
  input  logic [3:0]                     cfg_op,
  input  logic [DATA_W-1:0]              cfg_const,
  input  logic                           start_exec,
  input  logic [CTX_W-1:0]               ctx_max,
  input  logic [NUM_NEIGHBOR*DATA_W-1:0] in_data,
  input  logic [NUM_NEIGHBOR-1:0]        in_valid,
  output logic [NUM_NEIGHBOR-1:0]        in_stop,
  output logic [NUM_NEIGHBOR*DATA_W-1:0] out_data,
  output logic [NUM_NEIGHBOR-1:0]        out_valid,
  input  logic [NUM_NEIGHBOR-1:0]        out_stop,
  output logic [ADDR_W-1:0]              mem_rd_addr,
  input  logic [DATA_W-1:0]              mem_rd_data,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_wr_addr,
  output logic [DATA_W-1:0]              mem_wr_data,
  output logic [CTX_W-1:0]               ctx_idx,
  output logic                           busy
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int FW = $clog2(BUF_DEPTH + 1);
  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3, OP_DIV = 4'd4,
                         OP_CONST = 4'd5, OP_LOAD = 4'd6, OP_STORE = 4'd7, OP_ROUTE = 4'd8;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BUSY, S_PUSH} state_t;
  state_t r_state;
  logic [NB_W-1:0] r_cfg_a [CTX_DEPTH];
  logic [NB_W-1:0] r_cfg_b [CTX_DEPTH];
  logic [NUM_NEIGHBOR-1:0] r_cfg_m [CTX_DEPTH];
  logic [3:0] r_cfg_op [CTX_DEPTH];
  logic [DATA_W-1:0] r_cfg_k [CTX_DEPTH];
  logic [CTX_W-1:0] r_ctx;
  logic [3:0] r_op;
  logic [NUM_NEIGHBOR-1:0] r_mask, r_sent;
  logic [DATA_W-1:0] r_a, r_b, r_const, r_res;
  logic [7:0] r_cnt;
  logic [DATA_W-1:0] r_buf_d [BUF_DEPTH];
  logic [NUM_NEIGHBOR-1:0] r_buf_m [BUF_DEPTH];
  logic [PW-1:0] r_rp, r_wp;
  logic [FW-1:0] r_fcnt;
  logic [DATA_W-1:0] w_in [NUM_NEIGHBOR];
  logic [DATA_W-1:0] w_res;
  logic [3:0] w_op;
  logic [NB_W-1:0] w_sa, w_sb;
  logic [NUM_NEIGHBOR-1:0] w_need, w_xfer, w_hmask;
  logic [CTX_W-1:0] w_ctx_nxt;
  logic [7:0] w_lat;
  logic w_nop, w_ready, w_take, w_last, w_empty, w_full, w_pop, w_push;

  assign w_op = r_cfg_op[r_ctx];
  assign w_sa = r_cfg_a[r_ctx];
  assign w_sb = r_cfg_b[r_ctx];
  assign w_nop = w_op == OP_NOP || w_op > OP_ROUTE;
  assign w_lat = w_op == OP_MUL ? 8'(LAT_MUL) : w_op == OP_DIV ? 8'(LAT_DIV) : w_op == OP_LOAD ? 8'(LAT_LOAD) : 8'(LAT_ADD);
  assign w_ready = (in_valid & w_need) == w_need;
  assign w_take = r_state == S_WAIT && w_ready && !start_exec;
  assign in_stop = w_take ? ~w_need : '1;
  assign w_last = r_state == S_BUSY && r_cnt == 8'd1;
  assign w_ctx_nxt = (r_ctx >= ctx_max || r_ctx == CTX_W'(CTX_DEPTH - 1)) ? '0 : r_ctx + 1'b1;
  assign w_res = r_op == OP_SUB ? r_a - r_b : r_op == OP_MUL ? r_a * r_b :
                 r_op == OP_DIV ? (r_b == '0 ? '1 : r_a / r_b) : r_op == OP_CONST ? r_const :
                 r_op == OP_LOAD ? mem_rd_data : r_op == OP_ROUTE ? r_a : r_a + r_b;
  assign mem_rd_addr = (r_state == S_BUSY && r_op == OP_LOAD) ? r_a[ADDR_W-1:0] : '0;
  assign mem_wr = w_last && r_op == OP_STORE && !start_exec;
  assign mem_wr_addr = mem_wr ? r_a[ADDR_W-1:0] : '0;
  assign mem_wr_data = mem_wr ? r_b : '0;
  assign ctx_idx = r_ctx;
  assign busy = r_state != S_IDLE;
  assign w_empty = r_fcnt == '0;
  assign w_full = r_fcnt == FW'(BUF_DEPTH);
  assign w_hmask = r_buf_m[r_rp];
  assign out_valid = w_empty ? '0 : w_hmask & ~r_sent;
  assign w_xfer = out_valid & ~out_stop;
  assign w_pop = !w_empty && ((r_sent | w_xfer) & w_hmask) == w_hmask;
  assign w_push = r_state == S_PUSH && r_mask != '0 && (!w_full || w_pop) && !start_exec;

  // unpack neighbour inputs and replicate the FIFO head onto every output channel
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_NEIGHBOR; i++) begin
      w_in[i] = in_data[i*DATA_W +: DATA_W];
      out_data[i*DATA_W +: DATA_W] = w_empty ? '0 : r_buf_d[r_rp];
    end
  end

  // operand channels the current context must consume
  always_comb begin
    w_need = '0;
    if (w_op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_STORE, OP_LOAD, OP_ROUTE}) w_need[w_sa] = 1'b1;
    if (w_op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_STORE}) w_need[w_sb] = 1'b1;
  end

  // context memory, writable at any time
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < CTX_DEPTH; i++) begin
        r_cfg_a[i] <= '0;
        r_cfg_b[i] <= '0;
        r_cfg_m[i] <= '0;
        r_cfg_op[i] <= OP_NOP;
        r_cfg_k[i] <= '0;
      end
    end else if (cfg_we) begin
      r_cfg_a[cfg_idx] <= cfg_src_a;
      r_cfg_b[cfg_idx] <= cfg_src_b;
      r_cfg_m[cfg_idx] <= cfg_out_mask;
      r_cfg_op[cfg_idx] <= cfg_op;
      r_cfg_k[cfg_idx] <= cfg_const;
    end

  // execution FSM: fetch operands, count op latency, hand result to the FIFO
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ctx <= '0;
      r_op <= OP_NOP;
      r_mask <= '0;
      r_a <= '0;
      r_b <= '0;
      r_const <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else if (start_exec) begin
      r_state <= S_WAIT;
      r_ctx <= '0;
    end else begin
      case (r_state)
        S_WAIT:
          if (w_nop) r_ctx <= w_ctx_nxt;
          else if (w_ready) begin
            r_state <= S_BUSY;
            r_op <= w_op;
            r_mask <= r_cfg_m[r_ctx];
            r_const <= r_cfg_k[r_ctx];
            r_a <= w_in[w_sa];
            r_b <= w_in[w_sb];
            r_cnt <= w_lat;
          end
        S_BUSY:
          if (r_cnt == 8'd1) begin
            r_res <= w_res;
            r_state <= r_op == OP_STORE ? S_WAIT : S_PUSH;
            if (r_op == OP_STORE) r_ctx <= w_ctx_nxt;
          end else r_cnt <= r_cnt - 8'd1;
        S_PUSH:
          if (r_mask == '0 || !w_full || w_pop) begin
            r_state <= S_WAIT;
            r_ctx <= w_ctx_nxt;
          end
        default: ;
      endcase
    end

  // output FIFO with per-output sent tracking for the eager fork
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_rp <= '0;
      r_wp <= '0;
      r_fcnt <= '0;
      r_sent <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_d[i] <= '0;
        r_buf_m[i] <= '0;
      end
    end else if (start_exec) begin
      r_rp <= '0;
      r_wp <= '0;
      r_fcnt <= '0;
      r_sent <= '0;
    end else begin
      if (w_push) begin
        r_buf_d[r_wp] <= r_res;
        r_buf_m[r_wp] <= r_mask;
        r_wp <= r_wp == PW'(BUF_DEPTH - 1) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp == PW'(BUF_DEPTH - 1) ? '0 : r_rp + 1'b1;
        r_sent <= '0;
      end else r_sent <= r_sent | w_xfer;
      r_fcnt <= r_fcnt + FW'(w_push) - FW'(w_pop);
    end
endmodule

// File: tb/tb_elastic_pe_v2.sv
// tb_elastic_pe_v2: directed scenario tests for elastic_pe_v2
module tb_elastic_pe_v2;
  logic clk = 1'b0, reset_n = 1'b0, cfg_we = 1'b0, start_exec = 1'b0;
  logic [3:0] cfg_idx = '0, ctx_max = '0, cfg_op = '0, cfg_out_mask = '0, in_valid = '0, out_stop = '0;
  logic [1:0] cfg_src_a = '0, cfg_src_b = '0;
  logic [31:0] cfg_const = '0;
  logic [127:0] in_data = '0;
  logic [3:0] in_stop, out_valid, ctx_idx;
  logic [127:0] out_data;
  logic [15:0] mem_rd_addr, mem_wr_addr;
  logic [31:0] mem_rd_data, mem_wr_data;
  logic mem_wr, busy;
  int n_checks = 0, n_errors = 0;

  elastic_pe_v2 dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_src_a(cfg_src_a),
    .cfg_src_b(cfg_src_b), .cfg_out_mask(cfg_out_mask), .cfg_op(cfg_op), .cfg_const(cfg_const),
    .start_exec(start_exec), .ctx_max(ctx_max), .in_data(in_data), .in_valid(in_valid),
    .in_stop(in_stop), .out_data(out_data), .out_valid(out_valid), .out_stop(out_stop),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_wr(mem_wr),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .ctx_idx(ctx_idx), .busy(busy)
  );

  always #5 clk = ~clk;
  assign mem_rd_data = (mem_rd_addr == 16'h0040) ? 32'h0000_ABCD : 32'h1234_5678;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] idx, input logic [3:0] op, input logic [1:0] a,
                     input logic [1:0] b, input logic [3:0] m);
    cfg_we = 1'b1; cfg_idx = idx; cfg_op = op; cfg_src_a = a; cfg_src_b = b; cfg_out_mask = m;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic restart();
    start_exec = 1'b1;
    tick();
    start_exec = 1'b0;
  endtask

  task automatic send(input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1, output bit ok);
    in_data = {64'h0, d1, d0};
    in_valid = v;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      ok = (in_stop & v) == 4'h0;
      tick();
    end
    in_valid = '0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid == '0 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++; if (in_stop !== 4'hF) begin n_errors++; $display("FAIL reset_in_stop got %h want f", in_stop); end
    n_checks++; if (out_valid !== 4'h0) begin n_errors++; $display("FAIL reset_out_valid got %h want 0", out_valid); end
    n_checks++; if (busy !== 1'b0 || ctx_idx !== 4'h0) begin n_errors++; $display("FAIL reset_state busy %b ctx %h want 0 0", busy, ctx_idx); end
    n_checks++; if (mem_wr !== 1'b0 || mem_wr_addr !== 16'h0 || mem_rd_addr !== 16'h0 || out_data !== 128'h0) begin
      n_errors++; $display("FAIL reset_ports mem_wr %b wa %h ra %h od %h want all 0", mem_wr, mem_wr_addr, mem_rd_addr, out_data); end
    reset_n = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_add();
    int n;
    ctx_max = 4'd0;
    cfg(4'd0, 4'd1, 2'd0, 2'd1, 4'b0100);
    restart();
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL add_busy got %b want 1", busy); end
    in_data = {64'h0, 32'd7, 32'd5};
    in_valid = 4'b0011;
    #1;
    n_checks++; if (in_stop !== 4'b1100) begin n_errors++; $display("FAIL add_in_stop got %b want 1100", in_stop); end
    tick();
    in_valid = '0;
    #1;
    n_checks++; if (in_stop !== 4'hF) begin n_errors++; $display("FAIL add_in_stop_after got %b want 1111", in_stop); end
    wait_out(n);
    n_checks++; if (n != 2) begin n_errors++; $display("FAIL add_latency got %0d want 2", n); end
    n_checks++; if (out_valid !== 4'b0100 || out_data[95:64] !== 32'd12) begin
      n_errors++; $display("FAIL add_result valid %b data %0d want 0100 12", out_valid, out_data[95:64]); end
    tick();
    n_checks++; if (out_valid !== 4'h0 || ctx_idx !== 4'h0) begin
      n_errors++; $display("FAIL add_pop valid %b ctx %h want 0000 0", out_valid, ctx_idx); end
  endtask

  task automatic test_mul_fork();
    int n;
    bit ok;
    cfg(4'd0, 4'd3, 2'd0, 2'd1, 4'b0011);
    restart();
    out_stop = 4'b0010;
    send(4'b0011, 32'h0001_0000, 32'h0001_0000, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL mul_handshake got timeout want transfer"); end
    wait_out(n);
    n_checks++; if (n != 4) begin n_errors++; $display("FAIL mul_latency got %0d want 4", n); end
    n_checks++; if (out_valid !== 4'b0011 || out_data[31:0] !== 32'h0 || out_data[63:32] !== 32'h0) begin
      n_errors++; $display("FAIL mul_result valid %b d0 %h d1 %h want 0011 0 0", out_valid, out_data[31:0], out_data[63:32]); end
    tick();
    n_checks++; if (out_valid !== 4'b0010) begin n_errors++; $display("FAIL mul_out0_taken got %b want 0010", out_valid); end
    repeat (3) tick();
    n_checks++; if (out_valid !== 4'b0010) begin n_errors++; $display("FAIL mul_out1_stalled got %b want 0010", out_valid); end
    out_stop = '0;
    #1;
    n_checks++; if (out_valid !== 4'b0010) begin n_errors++; $display("FAIL mul_out1_release got %b want 0010", out_valid); end
    tick();
    n_checks++; if (out_valid !== 4'b0000) begin n_errors++; $display("FAIL mul_popped got %b want 0000", out_valid); end
  endtask

  task automatic test_div();
    int n;
    bit ok;
    cfg(4'd0, 4'd4, 2'd0, 2'd1, 4'b0001);
    restart();
    send(4'b0011, 32'd9, 32'd0, ok);
    wait_out(n);
    n_checks++; if (!ok || out_data[31:0] !== 32'hFFFF_FFFF) begin
      n_errors++; $display("FAIL div_by_zero ok %b got %h want ffffffff", ok, out_data[31:0]); end
    tick();
    send(4'b0011, 32'd9, 32'd2, ok);
    wait_out(n);
    n_checks++; if (!ok || n != 9) begin n_errors++; $display("FAIL div_latency ok %b got %0d want 9", ok, n); end
    n_checks++; if (out_data[31:0] !== 32'd4) begin n_errors++; $display("FAIL div_result got %0d want 4", out_data[31:0]); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] exp_r [3];
    exp_r = '{32'h11, 32'h22, 32'h33};
    out_stop = 4'hF;
    ctx_max = 4'd2;
    for (int k = 0; k < 3; k++) cfg(4'(k), 4'd8, 2'd0, 2'd0, 4'b0001);
    restart();
    for (int k = 0; k < 3; k++) begin
      send(4'b0001, exp_r[k], 32'h0, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL route_send%0d got timeout want transfer", k); end
    end
    repeat (4) tick();
    in_data = {96'h0, 32'h44};
    in_valid = 4'b0001;
    #1;
    n_checks++; if (ctx_idx !== 4'd2 || in_stop !== 4'hF) begin
      n_errors++; $display("FAIL route_hold ctx %h stop %b want 2 1111", ctx_idx, in_stop); end
    n_checks++; if (out_valid !== 4'b0001 || out_data[31:0] !== 32'h11) begin
      n_errors++; $display("FAIL route_head valid %b data %h want 0001 11", out_valid, out_data[31:0]); end
    tick();
    n_checks++; if (in_stop !== 4'hF) begin n_errors++; $display("FAIL route_hold_stop got %b want 1111", in_stop); end
    in_valid = '0;
    out_stop = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (out_valid !== 4'b0001 || out_data[31:0] !== exp_r[k]) begin
        n_errors++; $display("FAIL route_order%0d valid %b data %h want 0001 %h", k, out_valid, out_data[31:0], exp_r[k]); end
      tick();
    end
    n_checks++; if (out_valid !== 4'h0 || ctx_idx !== 4'h0) begin
      n_errors++; $display("FAIL route_drain valid %b ctx %h want 0000 0", out_valid, ctx_idx); end
  endtask

  task automatic test_load_store();
    int n, pulses;
    bit ok, seen_ov;
    logic [15:0] wa;
    logic [31:0] wd;
    ctx_max = 4'd1;
    cfg(4'd0, 4'd6, 2'd0, 2'd0, 4'b0001);
    cfg(4'd1, 4'd7, 2'd0, 2'd1, 4'b0000);
    restart();
    in_data = {96'h0, 32'h40};
    in_valid = 4'b0001;
    #1;
    n_checks++; if (in_stop !== 4'b1110) begin n_errors++; $display("FAIL load_in_stop got %b want 1110", in_stop); end
    tick();
    in_valid = '0;
    #1;
    n_checks++; if (mem_rd_addr !== 16'h0040) begin n_errors++; $display("FAIL load_addr got %h want 0040", mem_rd_addr); end
    wait_out(n);
    n_checks++; if (out_valid !== 4'b0001 || out_data[31:0] !== 32'hABCD) begin
      n_errors++; $display("FAIL load_result valid %b data %h want 0001 abcd", out_valid, out_data[31:0]); end
    tick();
    send(4'b0011, 32'h10, 32'd3, ok);
    pulses = 0; seen_ov = 1'b0; wa = '0; wd = '0;
    for (int i = 0; i < 10; i++) begin
      if (mem_wr) begin pulses++; wa = mem_wr_addr; wd = mem_wr_data; end
      if (out_valid != '0) seen_ov = 1'b1;
      tick();
    end
    n_checks++; if (!ok || pulses != 1) begin n_errors++; $display("FAIL store_pulses ok %b got %0d want 1", ok, pulses); end
    n_checks++; if (wa !== 16'h10 || wd !== 32'd3) begin n_errors++; $display("FAIL store_addr_data got %h %0d want 0010 3", wa, wd); end
    n_checks++; if (seen_ov) begin n_errors++; $display("FAIL store_no_token got out_valid want none"); end
  endtask

  task automatic test_abort();
    bit ok;
    out_stop = 4'hF;
    ctx_max = 4'd2;
    cfg(4'd0, 4'd8, 2'd0, 2'd0, 4'b0001);
    cfg(4'd1, 4'd8, 2'd0, 2'd0, 4'b0001);
    cfg(4'd2, 4'd3, 2'd0, 2'd1, 4'b0001);
    restart();
    send(4'b0001, 32'hA, 32'h0, ok);
    send(4'b0001, 32'hB, 32'h0, ok);
    send(4'b0011, 32'd5, 32'd6, ok);
    tick();
    n_checks++; if (!ok || out_valid !== 4'b0001 || busy !== 1'b1) begin
      n_errors++; $display("FAIL abort_pre ok %b valid %b busy %b want 1 0001 1", ok, out_valid, busy); end
    restart();
    n_checks++; if (out_valid !== 4'h0 || ctx_idx !== 4'h0 || out_data !== 128'h0) begin
      n_errors++; $display("FAIL abort_flush valid %b ctx %h data %h want 0 0 0", out_valid, ctx_idx, out_data); end
    out_stop = '0;
    repeat (6) tick();
    n_checks++; if (out_valid !== 4'h0) begin n_errors++; $display("FAIL abort_no_result got %b want 0000", out_valid); end
  endtask

  task automatic test_async_reset();
    bit ok;
    out_stop = 4'hF;
    restart();
    send(4'b0001, 32'h77, 32'h0, ok);
    repeat (3) tick();
    n_checks++; if (out_valid !== 4'b0001) begin n_errors++; $display("FAIL areset_pre got %b want 0001", out_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 4'h0 || busy !== 1'b0 || in_stop !== 4'hF || ctx_idx !== 4'h0 || out_data !== 128'h0) begin
      n_errors++; $display("FAIL areset valid %b busy %b stop %b ctx %h want 0 0 f 0", out_valid, busy, in_stop, ctx_idx); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_mul_fork();
    test_div();
    test_back_to_back();
    test_load_store();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
